vga_vram_arbiter: RTL and testbench

- Shares one single-port video RAM (one access per clock) between the VGA scanout reader and a pixel-writer (drawing/CPU side).
- Scanout reads have absolute priority and fixed latency, so the display never tears from contention.
- Writer requests go into a small FIFO and drain on cycles when the scanout is not reading, mainly during H/V blanking.
- Sits between the VGA timing generator (pixel address source) and the frame-buffer RAM.

---
 rtl/vga_vram_arbiter.sv | 137 +++++++++++++
 tb/tb_vga_vram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads win every cycle they ask,
// buffered pixel writes drain through a small FIFO whenever the RAM is free.
module vga_vram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iPixReq,
    input  logic [ADDR_W-1:0] iPixAddr,
    output logic              oPixValid,
    output logic [DATA_W-1:0] oPixData,
    input  logic              iWrEnable,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrColor,
    output logic              oWrFull,
    output logic              oWrOverflow,
    output logic [PTR_W:0]    oPendingCount,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic              oRamWe,
    output logic [DATA_W-1:0] oRamWData,
    input  logic [DATA_W-1:0] iRamRData
);

    localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = 1;
    localparam logic [PTR_W-1:0] C_PTR_ONE = 1;

    typedef enum logic [1:0] {
        GRANT_IDLE  = 2'd0,
        GRANT_READ  = 2'd1,
        GRANT_WRITE = 2'd2
    } grant_t;

    grant_t w_grant;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_full;
    logic              r_overflow;
    logic              r_rd_s1;
    logic              r_rd_s2;
    logic              r_pix_valid;
    logic [DATA_W-1:0] r_pix_data;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;

    logic              w_push;
    logic              w_pop;
    logic [PTR_W:0]    w_count_next;

    // Full is looked at as registered, so a pop in the same edge cannot rescue a push.
    assign w_push = iWrEnable & ~r_full;
    assign w_pop  = (w_grant == GRANT_WRITE);

    always_comb begin
        w_grant = GRANT_IDLE;
        if (iPixReq)
            w_grant = GRANT_READ;
        else if (r_count != '0)
            w_grant = GRANT_WRITE;
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + C_CNT_ONE;
            2'b01:   w_count_next = r_count - C_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_s1     <= 1'b0;
            r_rd_s2     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            case (w_grant)
                GRANT_READ: begin
                    r_ram_addr <= iPixAddr;
                    r_ram_we   <= 1'b0;
                end
                GRANT_WRITE: begin
                    r_ram_addr  <= r_fifo_addr[r_rd_ptr];
                    r_ram_wdata <= r_fifo_data[r_rd_ptr];
                    r_ram_we    <= 1'b1;
                end
                default: r_ram_we <= 1'b0;
            endcase

            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            r_count <= w_count_next;
            r_full  <= (w_count_next == C_DEPTH);
            if (iWrEnable && r_full) r_overflow <= 1'b1;

            // RAM answers one cycle after it sees the address, so capture on the second stage.
            r_rd_s1     <= (w_grant == GRANT_READ);
            r_rd_s2     <= r_rd_s1;
            r_pix_valid <= r_rd_s2;
            if (r_rd_s2) r_pix_data <= iRamRData;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && w_push) begin
            r_fifo_addr[r_wr_ptr] <= iWrAddr;
            r_fifo_data[r_wr_ptr] <= iWrColor;
        end
    end

    assign oPixValid     = r_pix_valid;
    assign oPixData      = r_pix_data;
    assign oWrFull       = r_full;
    assign oWrOverflow   = r_overflow;
    assign oPendingCount = r_count;
    assign oRamAddr      = r_ram_addr;
    assign oRamWe        = r_ram_we;
    assign oRamWData     = r_ram_wdata;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: frame-buffer RAM model, queue-based reference of the
// arbiter, per-cycle compare, directed literal checks, then randomized traffic.
module tb_vga_vram_arbiter;
    localparam int AW = 19;
    localparam int DW = 3;
    localparam int FD = 4;
    localparam int PW = 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iPixReq = 1'b0;
    logic [AW-1:0] iPixAddr = '0;
    logic          oPixValid;
    logic [DW-1:0] oPixData;
    logic          iWrEnable = 1'b0;
    logic [AW-1:0] iWrAddr = '0;
    logic [DW-1:0] iWrColor = '0;
    logic          oWrFull;
    logic          oWrOverflow;
    logic [PW:0]   oPendingCount;
    logic [AW-1:0] oRamAddr;
    logic          oRamWe;
    logic [DW-1:0] oRamWData;
    logic [DW-1:0] iRamRData = '0;

    vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .PTR_W(PW)) dut (
        .Clock(Clock), .Reset(Reset),
        .iPixReq(iPixReq), .iPixAddr(iPixAddr),
        .oPixValid(oPixValid), .oPixData(oPixData),
        .iWrEnable(iWrEnable), .iWrAddr(iWrAddr), .iWrColor(iWrColor),
        .oWrFull(oWrFull), .oWrOverflow(oWrOverflow), .oPendingCount(oPendingCount),
        .oRamAddr(oRamAddr), .oRamWe(oRamWe), .oRamWData(oRamWData),
        .iRamRData(iRamRData)
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- frame-buffer RAM (environment) ----------------
    logic [DW-1:0] ram_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_pix(input logic [AW-1:0] a);
        logic [AW-1:0] v;
        v = a;
        return v[2:0] ^ v[5:3];
    endfunction

    function automatic logic [DW-1:0] ram_lookup(input logic [AW-1:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_pix(a);
    endfunction

    always @(posedge Clock) begin
        logic [DW-1:0] rd;
        rd = ram_lookup(oRamAddr);
        if (oRamWe === 1'b1) ram_mem[oRamAddr] = oRamWData;
        iRamRData <= rd;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           m_q[$];
    logic [DW-1:0] m_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q[$];
    int            exp_due_q[$];
    int            m_cycle = 0;
    bit            m_ready = 0;
    logic          m_we = 0, m_pv = 0, m_ovf = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_pd = '0;

    function automatic logic [DW-1:0] model_lookup(input logic [AW-1:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return init_pix(a);
    endfunction

    // A read sees every write granted before it; its pixel shows up two edges later.
    always @(posedge Clock) begin
        bit  was_full;
        wr_t e;
        if (Reset) begin
            m_q.delete();
            exp_q.delete();
            exp_due_q.delete();
            m_we = 0; m_pv = 0; m_ovf = 0;
            m_addr = '0; m_wdata = '0; m_pd = '0;
            m_ready = 1;
        end else begin
            was_full = (m_q.size() == FD);
            m_pv = 0;
            if (exp_due_q.size() > 0 && exp_due_q[0] == m_cycle) begin
                m_pv = 1;
                m_pd = exp_q.pop_front();
                void'(exp_due_q.pop_front());
            end
            if (iPixReq) begin
                m_addr = iPixAddr;
                m_we   = 0;
                exp_q.push_back(model_lookup(iPixAddr));
                exp_due_q.push_back(m_cycle + 2);
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_addr  = e.a;
                m_wdata = e.d;
                m_we    = 1;
                m_mem[e.a] = e.d;
            end else begin
                m_we = 0;
            end
            if (iWrEnable) begin
                if (was_full) m_ovf = 1;
                else begin
                    e.a = iWrAddr;
                    e.d = iWrColor;
                    m_q.push_back(e);
                end
            end
        end
        m_cycle++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clock) begin
        if (m_ready) begin
            chk("cmp_we", 32'(oRamWe), 32'(m_we));
            chk("cmp_addr", 32'(oRamAddr), 32'(m_addr));
            chk("cmp_wdata", 32'(oRamWData), 32'(m_wdata));
            chk("cmp_pvalid", 32'(oPixValid), 32'(m_pv));
            chk("cmp_pdata", 32'(oPixData), 32'(m_pd));
            chk("cmp_full", 32'(oWrFull), 32'(m_q.size() == FD));
            chk("cmp_ovf", 32'(oWrOverflow), 32'(m_ovf));
            chk("cmp_count", 32'(oPendingCount), 32'(m_q.size()));
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_push(input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        iWrEnable = en;
        iWrAddr   = a;
        iWrColor  = d;
    endtask

    initial begin
        ram_mem[19'h00010] = 3'b100;
        m_mem[19'h00010]   = 3'b100;

        // reset with a push held high
        Reset = 1; iPixReq = 0;
        set_push(1, 19'h7, 3'b001);
        step(); step();
        chk("rst_we", 32'(oRamWe), 0);
        chk("rst_pvalid", 32'(oPixValid), 0);
        chk("rst_full", 32'(oWrFull), 0);
        chk("rst_ovf", 32'(oWrOverflow), 0);
        chk("rst_count", 32'(oPendingCount), 0);
        Reset = 0;
        set_push(0, '0, '0);
        step();
        chk("rst_nostore_count", 32'(oPendingCount), 0);
        chk("rst_nostore_we", 32'(oRamWe), 0);

        // read latency
        iPixReq = 1; iPixAddr = 19'h00010;
        step();
        chk("rd_addr", 32'(oRamAddr), 32'h10);
        chk("rd_we", 32'(oRamWe), 0);
        chk("rd_valid_t", 32'(oPixValid), 0);
        iPixReq = 0;
        step();
        chk("rd_valid_t1", 32'(oPixValid), 0);
        step();
        chk("rd_valid_t2", 32'(oPixValid), 1);
        chk("rd_data_t2", 32'(oPixData), 32'b100);
        step();
        chk("rd_valid_t3", 32'(oPixValid), 0);
        chk("rd_data_hold", 32'(oPixData), 32'b100);

        // idle drain
        set_push(1, 19'h5, 3'b010);
        step();
        set_push(0, '0, '0);
        chk("drain_count1", 32'(oPendingCount), 1);
        chk("drain_no_bypass", 32'(oRamWe), 0);
        step();
        chk("drain_we", 32'(oRamWe), 1);
        chk("drain_addr", 32'(oRamAddr), 32'h5);
        chk("drain_wdata", 32'(oRamWData), 32'b010);
        chk("drain_count0", 32'(oPendingCount), 0);
        step();
        chk("drain_we_off", 32'(oRamWe), 0);

        // reads starve writes
        iPixReq = 1; iPixAddr = 19'h20;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) set_push(1, AW'(i + 1), DW'(i + 5));
            else set_push(0, '0, '0);
            step();
            chk("prio_no_we", 32'(oRamWe), 0);
        end
        chk("prio_count", 32'(oPendingCount), 3);
        iPixReq = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("prio_we", 32'(oRamWe), 1);
            chk("prio_addr", 32'(oRamAddr), 32'(i + 1));
            chk("prio_wdata", 32'(oRamWData), 32'(i + 5));
        end
        chk("prio_count0", 32'(oPendingCount), 0);

        // overflow
        iPixReq = 1;
        for (int i = 0; i < 5; i++) begin
            set_push(1, AW'(32'h100 + i), DW'(i));
            step();
            if (i == 3) chk("ovf_full4", 32'(oWrFull), 1);
        end
        set_push(0, '0, '0);
        chk("ovf_set", 32'(oWrOverflow), 1);
        chk("ovf_count", 32'(oPendingCount), 4);
        iPixReq = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ovf_we", 32'(oRamWe), 1);
            chk("ovf_addr", 32'(oRamAddr), 32'h100 + i);
        end
        step();
        chk("ovf_only4", 32'(oRamWe), 0);
        chk("ovf_sticky", 32'(oWrOverflow), 1);

        // reset mid-operation
        iPixReq = 1; iPixAddr = 19'h33;
        for (int i = 0; i < 3; i++) begin
            set_push(1, AW'(32'h200 + i), DW'(i));
            step();
        end
        set_push(0, '0, '0);
        chk("mid_count3", 32'(oPendingCount), 3);
        Reset = 1; iPixReq = 0;
        step();
        Reset = 0;
        chk("mid_count0", 32'(oPendingCount), 0);
        chk("mid_ovf_clr", 32'(oWrOverflow), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_we", 32'(oRamWe), 0);
            chk("mid_no_valid", 32'(oPixValid), 0);
        end

        // randomized traffic: scanout bursts with blanking gaps
        for (int c = 0; c < 3000; c++) begin
            Reset     = ($urandom_range(0, 399) == 0);
            iPixReq   = ((c % 40) < 28) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
            iPixAddr  = AW'($urandom_range(0, 31));
            iWrEnable = ($urandom_range(0, 2) == 0);
            iWrAddr   = AW'($urandom_range(0, 31));
            iWrColor  = DW'($urandom_range(0, 7));
            step();
        end
        Reset = 0; iPixReq = 0; iWrEnable = 0;
        for (int c = 0; c < 10; c++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
